force_watch_monitor: RTL and testbench

- Downstream consumer of a registered WIDTH-bit status output driven by a sub-block register (e.g. a 4-bit `out` fed from a flop).
- Compares each qualified sample against an expected value and locks once the value has been stable for LOCK_LEN samples.
- Flags, counts and captures unexpected values, such as a `force` override of the producer register or port.
- Used in regression benches and in-design self-checks to prove forced values propagate and release correctly.

---
 rtl/force_watch_if.sv | 27 ++
 rtl/force_watch_monitor.sv | 128 ++++++++++++
 tb/tb_force_watch_monitor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/force_watch_if.sv
// Bus bundle between a watched producer/bench and force_watch_monitor.
// The master drives the sample and qualifiers; the slave returns monitor status.
interface force_watch_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] exp_val;
  logic             exp_valid;
  logic [1:0]       state;
  logic             mismatch;
  logic             sticky_err;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [WIDTH-1:0] last_bad;

  modport master (
    output en, clr, din, exp_val, exp_valid,
    input  state, mismatch, sticky_err, mismatch_cnt, last_bad
  );

  modport slave (
    input  en, clr, din, exp_val, exp_valid,
    output state, mismatch, sticky_err, mismatch_cnt, last_bad
  );
endinterface

// File: rtl/force_watch_monitor.sv
// Watches a registered status value, locks after LOCK_LEN matching samples,
// and records any unexpected value (e.g. a forced override) with sticky/count/capture.
module force_watch_monitor #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_LEN = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  force_watch_if.slave  bus
);

  localparam int unsigned RUN_W = 8;
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             mismatch_q, mismatch_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;

  logic match_c;
  logic mism_c;

  // A compare only happens when enabled, qualified and out of IDLE
  assign match_c = (bus.din == bus.exp_val);
  assign mism_c  = bus.en && bus.exp_valid && (state_q != IDLE) && !match_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      run_q      <= '0;
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      mismatch_q <= mismatch_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    mismatch_d = 1'b0;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;
    last_d     = last_q;

    if (!bus.en) begin
      state_d = IDLE;
      run_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (bus.exp_valid) begin
            if (match_c) begin
              // run never exceeds LOCK_LEN, so reaching it is the lock condition
              if (run_q >= LOCK_RUN - RUN_W'(1)) begin
                run_d   = LOCK_RUN;
                state_d = LOCKED;
              end else begin
                run_d = run_q + RUN_W'(1);
              end
            end else begin
              state_d = FAULT;
              run_d   = '0;
            end
          end
        end
        LOCKED: begin
          if (bus.exp_valid && !match_c) begin
            state_d = FAULT;
            run_d   = '0;
          end
        end
        FAULT: begin
          if (bus.exp_valid && match_c) begin
            run_d   = RUN_W'(1);
            state_d = (LOCK_LEN == 1) ? LOCKED : ARMED;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end

    if (mism_c) begin
      mismatch_d = 1'b1;
      sticky_d   = 1'b1;
      last_d     = bus.din;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end

    // Clear overrides the error record only; pulse and FSM move are unaffected
    if (bus.clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
      last_d   = '0;
    end
  end

  assign bus.state        = state_q;
  assign bus.mismatch     = mismatch_q;
  assign bus.sticky_err   = sticky_q;
  assign bus.mismatch_cnt = cnt_q;
  assign bus.last_bad     = last_q;

endmodule

// File: tb/tb_force_watch_monitor.sv
// Directed self-checking bench for force_watch_monitor (WIDTH=4, LOCK_LEN=3, CNT_W=4).
module tb_force_watch_monitor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  force_watch_if #(.WIDTH(4), .CNT_W(4)) bus ();

  force_watch_monitor #(.WIDTH(4), .LOCK_LEN(3), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic mm,
                         input logic se, input logic [3:0] cnt, input logic [3:0] lb);
    chk({tag, ".state"},      32'(bus.state),        32'(st));
    chk({tag, ".mismatch"},   32'(bus.mismatch),     32'(mm));
    chk({tag, ".sticky"},     32'(bus.sticky_err),   32'(se));
    chk({tag, ".cnt"},        32'(bus.mismatch_cnt), 32'(cnt));
    chk({tag, ".last_bad"},   32'(bus.last_bad),     32'(lb));
  endtask

  initial begin
    bus.en        = 1'b0;
    bus.clr       = 1'b0;
    bus.din       = 4'hF;
    bus.exp_val   = 4'h0;
    bus.exp_valid = 1'b0;

    // 1. reset held for two cycles
    step();
    step();
    chk_all("reset", 2'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    rst_n = 1'b1;

    // 2. lock-up
    bus.en = 1'b1; bus.exp_valid = 1'b1; bus.din = 4'h1; bus.exp_val = 4'h1;
    step(); chk_all("arm",   2'd1, 1'b0, 1'b0, 4'h0, 4'h0);
    step(); chk_all("run1",  2'd1, 1'b0, 1'b0, 4'h0, 4'h0);
    step(); chk_all("run2",  2'd1, 1'b0, 1'b0, 4'h0, 4'h0);
    step(); chk_all("lock",  2'd2, 1'b0, 1'b0, 4'h0, 4'h0);

    // 3. forced override for one cycle, then recovery
    bus.din = 4'h3;
    step(); chk_all("force", 2'd3, 1'b1, 1'b1, 4'h1, 4'h3);
    bus.din = 4'h1;
    step(); chk_all("rel0",  2'd1, 1'b0, 1'b1, 4'h1, 4'h3);
    step(); chk_all("rel1",  2'd1, 1'b0, 1'b1, 4'h1, 4'h3);
    step(); chk_all("rel2",  2'd2, 1'b0, 1'b1, 4'h1, 4'h3);

    // LOCKED ignores unqualified bad data
    bus.exp_valid = 1'b0; bus.din = 4'hA;
    step(); chk_all("lock_nv", 2'd2, 1'b0, 1'b1, 4'h1, 4'h3);

    // 4. 20 back-to-back mismatches saturate the counter at F
    bus.exp_valid = 1'b1; bus.din = 4'h5;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk_all($sformatf("sat%0d", i), 2'd3, 1'b1, 1'b1,
              (1 + i > 15) ? 4'hF : 4'(1 + i), 4'h5);
    end

    // 5. clear colliding with a mismatch
    bus.din = 4'h2; bus.clr = 1'b1;
    step(); chk_all("clr_hit", 2'd3, 1'b1, 1'b0, 4'h0, 4'h0);
    bus.clr = 1'b0; bus.din = 4'h9;
    step(); chk_all("post_clr", 2'd3, 1'b1, 1'b1, 4'h1, 4'h9);

    // FAULT holds with no compare
    bus.exp_valid = 1'b0;
    step(); chk_all("fault_nv", 2'd3, 1'b0, 1'b1, 4'h1, 4'h9);

    // 6. disable during a mismatch: no pulse, record retained
    bus.en = 1'b0; bus.exp_valid = 1'b1; bus.din = 4'h7;
    step(); chk_all("dis", 2'd0, 1'b0, 1'b1, 4'h1, 4'h9);
    // IDLE never compares even once enabled on that edge
    bus.en = 1'b1;
    step(); chk_all("rearm", 2'd1, 1'b0, 1'b1, 4'h1, 4'h9);
    // ARMED holds run with exp_valid low
    bus.exp_valid = 1'b0; bus.din = 4'h6;
    step(); chk_all("arm_nv", 2'd1, 1'b0, 1'b1, 4'h1, 4'h9);
    bus.exp_valid = 1'b1; bus.din = 4'h1;
    step(); chk_all("relk1", 2'd1, 1'b0, 1'b1, 4'h1, 4'h9);
    step(); chk_all("relk2", 2'd1, 1'b0, 1'b1, 4'h1, 4'h9);
    step(); chk_all("relk3", 2'd2, 1'b0, 1'b1, 4'h1, 4'h9);

    // asynchronous reset while LOCKED, observed before the next edge
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 2'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    bus.en = 1'b0;
    step();
    rst_n = 1'b1;
    step(); chk_all("post_rst", 2'd0, 1'b0, 1'b0, 4'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound the run in case the sequence ever stalls
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
